// File: rtl/fas_pkg.sv
// Shared constants and types for the FAS frequency-analysis stage.
package fas_pkg;

  localparam int DW   = 16;
  localparam int NBIN = 16;
  localparam int MAGW = 2 * DW + 1;
  localparam int IDXW = $clog2(NBIN);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } bin_t;

endpackage

// File: rtl/fas_mag_sq.sv
// Combinational squared magnitude re^2 + im^2 of one FFT bin.
module fas_mag_sq
  import fas_pkg::*;
(
  input  bin_t            bin,
  output logic [MAGW-1:0] mag
);

  logic signed [2*DW-1:0] re_ext;
  logic signed [2*DW-1:0] im_ext;
  logic signed [2*DW-1:0] re_sq;
  logic signed [2*DW-1:0] im_sq;

  // Squares are non-negative and at most 2^30, so the 33-bit sum of two never wraps.
  always_comb begin
    re_ext = {{DW{bin.re[DW-1]}}, bin.re};
    im_ext = {{DW{bin.im[DW-1]}}, bin.im};
    re_sq  = re_ext * re_ext;
    im_sq  = im_ext * im_ext;
    mag    = {1'b0, re_sq} + {1'b0, im_sq};
  end

endmodule

// File: rtl/fas_analysis.sv
// Peak-bin finder over 16-bin FFT frames: scans one bin per cycle,
// with a one-deep pending bank so back-to-back frames are not lost.
module fas_analysis
  import fas_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            fft_valid,
  input  logic [2*DW-1:0] fft_d0,
  input  logic [2*DW-1:0] fft_d1,
  input  logic [2*DW-1:0] fft_d2,
  input  logic [2*DW-1:0] fft_d3,
  input  logic [2*DW-1:0] fft_d4,
  input  logic [2*DW-1:0] fft_d5,
  input  logic [2*DW-1:0] fft_d6,
  input  logic [2*DW-1:0] fft_d7,
  input  logic [2*DW-1:0] fft_d8,
  input  logic [2*DW-1:0] fft_d9,
  input  logic [2*DW-1:0] fft_d10,
  input  logic [2*DW-1:0] fft_d11,
  input  logic [2*DW-1:0] fft_d12,
  input  logic [2*DW-1:0] fft_d13,
  input  logic [2*DW-1:0] fft_d14,
  input  logic [2*DW-1:0] fft_d15,
  output logic            done,
  output logic [IDXW-1:0] freq,
  output logic            overrun
);

  bin_t in_bank [NBIN];

  state_t          state_q, state_d;
  bin_t            scan_bank_q [NBIN];
  bin_t            scan_bank_d [NBIN];
  bin_t            pend_bank_q [NBIN];
  bin_t            pend_bank_d [NBIN];
  logic            pend_valid_q, pend_valid_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [MAGW-1:0] best_mag_q, best_mag_d;
  logic [IDXW-1:0] best_idx_q, best_idx_d;
  logic            done_q, done_d;
  logic [IDXW-1:0] freq_q, freq_d;
  logic            overrun_q, overrun_d;

  logic [MAGW-1:0] mag;
  logic            better;
  logic [MAGW-1:0] cand_mag;
  logic [IDXW-1:0] cand_idx;
  logic            last_bin;

  always_comb begin
    in_bank[0]  = fft_d0;
    in_bank[1]  = fft_d1;
    in_bank[2]  = fft_d2;
    in_bank[3]  = fft_d3;
    in_bank[4]  = fft_d4;
    in_bank[5]  = fft_d5;
    in_bank[6]  = fft_d6;
    in_bank[7]  = fft_d7;
    in_bank[8]  = fft_d8;
    in_bank[9]  = fft_d9;
    in_bank[10] = fft_d10;
    in_bank[11] = fft_d11;
    in_bank[12] = fft_d12;
    in_bank[13] = fft_d13;
    in_bank[14] = fft_d14;
    in_bank[15] = fft_d15;
  end

  fas_mag_sq u_mag_sq (
    .bin (scan_bank_q[idx_q]),
    .mag (mag)
  );

  // Strict compare keeps the lower index on ties.
  assign better   = mag > best_mag_q;
  assign cand_mag = better ? mag : best_mag_q;
  assign cand_idx = better ? idx_q : best_idx_q;
  assign last_bin = idx_q == IDXW'(NBIN - 1);

  always_comb begin
    state_d      = state_q;
    scan_bank_d  = scan_bank_q;
    pend_bank_d  = pend_bank_q;
    pend_valid_d = pend_valid_q;
    idx_d        = idx_q;
    best_mag_d   = best_mag_q;
    best_idx_d   = best_idx_q;
    done_d       = 1'b0;
    freq_d       = freq_q;
    overrun_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (fft_valid) begin
          scan_bank_d = in_bank;
          idx_d       = '0;
          best_mag_d  = '0;
          best_idx_d  = '0;
          state_d     = SCAN;
        end
      end

      SCAN: begin
        best_mag_d = cand_mag;
        best_idx_d = cand_idx;
        idx_d      = idx_q + 1'b1;
        if (last_bin) begin
          done_d     = 1'b1;
          freq_d     = cand_idx;
          idx_d      = '0;
          best_mag_d = '0;
          best_idx_d = '0;
          // A held frame takes priority; a frame arriving now then refills pending.
          if (pend_valid_q) begin
            scan_bank_d = pend_bank_q;
            if (fft_valid) begin
              pend_bank_d = in_bank;
            end else begin
              pend_valid_d = 1'b0;
            end
          end else if (fft_valid) begin
            scan_bank_d = in_bank;
          end else begin
            state_d = IDLE;
          end
        end else if (fft_valid) begin
          pend_bank_d  = in_bank;
          pend_valid_d = 1'b1;
          overrun_d    = pend_valid_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pend_valid_q <= 1'b0;
      idx_q        <= '0;
      best_mag_q   <= '0;
      best_idx_q   <= '0;
      done_q       <= 1'b0;
      freq_q       <= '0;
      overrun_q    <= 1'b0;
      for (int k = 0; k < NBIN; k++) begin
        scan_bank_q[k] <= '0;
        pend_bank_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      scan_bank_q  <= scan_bank_d;
      pend_bank_q  <= pend_bank_d;
      pend_valid_q <= pend_valid_d;
      idx_q        <= idx_d;
      best_mag_q   <= best_mag_d;
      best_idx_q   <= best_idx_d;
      done_q       <= done_d;
      freq_q       <= freq_d;
      overrun_q    <= overrun_d;
    end
  end

  assign done    = done_q;
  assign freq    = freq_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_fas_analysis.sv
// Self-checking bench for fas_analysis: vector table for peak selection,
// hand-written sequences for back-to-back, overrun and mid-scan reset.
module tb_fas_analysis;

  typedef logic [31:0] frame_t [16];

  typedef struct {
    logic [15:0] bg_re;
    logic [15:0] bg_im;
    int          a;
    logic [15:0] a_re;
    logic [15:0] a_im;
    int          b;
    logic [15:0] b_re;
    logic [15:0] b_im;
    logic [3:0]  exp_freq;
  } vec_t;

  typedef struct {
    logic [3:0] f;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fft_valid = 1'b0;
  logic       done;
  logic [3:0] freq;
  logic       overrun;

  frame_t din;
  frame_t cur_frame;
  vec_t   vecs [8];
  exp_t   sb [$];
  int     ov_sb [$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int unexp_done = 0;
  int unexp_ov = 0;
  int mon_label;
  exp_t mon_e;
  int mon_ov;
  int snap_done;
  int snap_ov;

  fas_analysis dut (
    .clk       (clk),
    .rst       (rst),
    .fft_valid (fft_valid),
    .fft_d0    (din[0]),
    .fft_d1    (din[1]),
    .fft_d2    (din[2]),
    .fft_d3    (din[3]),
    .fft_d4    (din[4]),
    .fft_d5    (din[5]),
    .fft_d6    (din[6]),
    .fft_d7    (din[7]),
    .fft_d8    (din[8]),
    .fft_d9    (din[9]),
    .fft_d10   (din[10]),
    .fft_d11   (din[11]),
    .fft_d12   (din[12]),
    .fft_d13   (din[13]),
    .fft_d14   (din[14]),
    .fft_d15   (din[15]),
    .done      (done),
    .freq      (freq),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Cycle label counts the period ending at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      mon_label = cyc + 1;
      if (done) begin
        if (sb.size() == 0) begin
          unexp_done++;
          checkOutput("unexpected_done", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("done_freq", freq, mon_e.f);
          checkOutput("done_cycle", mon_label, mon_e.due);
        end
      end
      if (overrun) begin
        if (ov_sb.size() == 0) begin
          unexp_ov++;
          checkOutput("unexpected_overrun", 1, 0);
        end else begin
          mon_ov = ov_sb.pop_front();
          checkOutput("overrun_cycle", mon_label, mon_ov);
        end
      end
    end
  end

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic buildFrame(input vec_t v);
    for (int k = 0; k < 16; k++) cur_frame[k] = {v.bg_re, v.bg_im};
    cur_frame[v.a] = {v.a_re, v.a_im};
    cur_frame[v.b] = {v.b_re, v.b_im};
  endtask

  task automatic buildPeak(input int bin);
    for (int k = 0; k < 16; k++) cur_frame[k] = 32'h0;
    cur_frame[bin] = {16'h0200, 16'h0000};
  endtask

  // Called at a falling edge; drives one frame strobe for a single cycle.
  task automatic applyStimulus(input logic [3:0] ef, input int latency, input bit replace);
    exp_t e;
    e.f   = ef;
    e.due = cyc + 1 + latency;
    if (replace) begin
      void'(sb.pop_back());
      ov_sb.push_back(cyc + 2);
    end
    sb.push_back(e);
    din       = cur_frame;
    fft_valid = 1'b1;
    @(negedge clk);
    fft_valid = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || ov_sb.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_pending_results", sb.size() + ov_sb.size(), 0);
    sb.delete();
    ov_sb.delete();
  endtask

  initial begin
    vecs[0] = '{16'h0010, 16'h0010, 0,  16'h0400, 16'h0000, 0,  16'h0400, 16'h0000, 4'd0};
    vecs[1] = '{16'h0000, 16'h0000, 3,  16'hF000, 16'h0000, 9,  16'h1000, 16'h0000, 4'd3};
    vecs[2] = '{16'h0000, 16'h0000, 15, 16'h8000, 16'h8000, 14, 16'h7FFF, 16'h7FFF, 4'd15};
    vecs[3] = '{16'h0000, 16'h0000, 0,  16'h0000, 16'h0000, 0,  16'h0000, 16'h0000, 4'd0};
    vecs[4] = '{16'h0001, 16'h0001, 7,  16'h0000, 16'hFF00, 12, 16'h00FF, 16'h0000, 4'd7};
    vecs[5] = '{16'h0100, 16'h0100, 10, 16'h0100, 16'h0101, 10, 16'h0100, 16'h0101, 4'd10};
    vecs[6] = '{16'h0020, 16'hFFE0, 0,  16'h0020, 16'hFFE0, 0,  16'h0020, 16'hFFE0, 4'd0};
    vecs[7] = '{16'h0000, 16'h0000, 15, 16'h8000, 16'h0000, 1,  16'h7FFF, 16'h7FFF, 4'd1};

    for (int k = 0; k < 16; k++) din[k] = 32'h0;

    #22;
    checkOutput("reset_done", done, 0);
    checkOutput("reset_freq", freq, 0);
    checkOutput("reset_overrun", overrun, 0);
    @(negedge clk);
    rst = 1'b0;
    idleCycles(2);

    for (int i = 0; i < 8; i++) begin
      snap_ov = unexp_ov;
      buildFrame(vecs[i]);
      applyStimulus(vecs[i].exp_freq, 17, 1'b0);
      waitDrain(40);
      checkOutput("vector_freq_held", freq, vecs[i].exp_freq);
      checkOutput("vector_no_overrun", unexp_ov - snap_ov, 0);
      idleCycles(3);
    end

    $display("[TB] back-to-back frames");
    snap_ov = unexp_ov;
    buildPeak(5);
    applyStimulus(4'd5, 17, 1'b0);
    idleCycles(15);
    buildPeak(7);
    applyStimulus(4'd7, 17, 1'b0);
    idleCycles(15);
    buildPeak(2);
    applyStimulus(4'd2, 17, 1'b0);
    waitDrain(60);
    checkOutput("b2b_no_overrun", unexp_ov - snap_ov, 0);
    idleCycles(3);

    $display("[TB] overrun");
    buildPeak(1);
    applyStimulus(4'd1, 17, 1'b0);
    idleCycles(2);
    buildPeak(4);
    applyStimulus(4'd4, 30, 1'b0);
    idleCycles(1);
    buildPeak(6);
    applyStimulus(4'd6, 28, 1'b1);
    waitDrain(60);
    checkOutput("overrun_freq_held", freq, 6);
    idleCycles(3);

    $display("[TB] reset mid-scan");
    buildPeak(1);
    applyStimulus(4'd1, 17, 1'b0);
    idleCycles(2);
    buildPeak(4);
    applyStimulus(4'd4, 30, 1'b0);
    idleCycles(4);
    rst = 1'b1;
    sb.delete();
    ov_sb.delete();
    #1;
    checkOutput("midreset_done", done, 0);
    checkOutput("midreset_freq", freq, 0);
    checkOutput("midreset_overrun", overrun, 0);
    @(negedge clk);
    rst = 1'b0;
    snap_done = unexp_done;
    idleCycles(40);
    checkOutput("no_done_after_reset", unexp_done - snap_done, 0);
    buildPeak(9);
    applyStimulus(4'd9, 17, 1'b0);
    waitDrain(40);
    checkOutput("after_reset_freq_held", freq, 9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
